parity_frame_rx: RTL

Serial frame receiver and parity checker: the receiving end of the team's parity generator path. It recovers 8-bit words from an asynchronous serial line, recomputes parity and compares it with the transmitted parity bit. It flags parity and framing errors and counts errored frames. It sits between the board-level serial input and the byte-wide consumer logic.

---
 rtl/parity_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/parity_frame_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame path: parity sense, word width
// and the receiver FSM state encoding.
package parity_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs; resets to 1 (idle line).
// Ports: clk, rst_n (async active-low), din (async input), dout (synchronized).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, 8 data bits LSB first, parity, stop.
// Recomputes parity, flags parity/framing errors, counts errored frames.
// Ports: clk, rst_n (async active-low), serial_in (async, idle high),
//        data_out, data_valid (1-cycle pulse), parity_err, frame_err,
//        err_count (saturating), busy (FSM not idle).
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          ODD_PARITY   = PARITY_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;
    localparam logic [7:0]  ERR_MAX = 8'hFF;

    logic rx_s;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              busy_q, busy_d;

    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (serial_in),
        .dout (rx_s)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            armed_q      <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            armed_q      <= armed_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        armed_d      = armed_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        err_count_d  = err_count_q;

        // Re-arm once the line has returned high after a break
        if (rx_s) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s && armed_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_M1)) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s != ((^shift_q) ^ ODD_PARITY));
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so an immediately following start is caught
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d        = '0;
                    data_out_d   = shift_q;
                    parity_err_d = par_bad_q;
                    frame_err_d  = !rx_s;
                    data_valid_d = 1'b1;
                    if ((par_bad_q || !rx_s) && (err_count_q != ERR_MAX))
                        err_count_d = err_count_q + 8'd1;
                    if (!rx_s) armed_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule
